// File: rtl/wb_pkg.sv
// Shared core constants for the write-back stage: datapath widths, CSR addresses
// and the CSR read/modify/write operation encoding.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  typedef enum logic [1:0] {
    CSR_OP_NONE,
    CSR_OP_WRITE,
    CSR_OP_SET,
    CSR_OP_CLEAR
  } csr_op_e;

  function automatic logic [XLEN-1:0] csrApply(csr_op_e op, logic [XLEN-1:0] oldVal,
                                               logic [XLEN-1:0] info);
    case (op)
      CSR_OP_WRITE: return info;
      CSR_OP_SET:   return oldVal | info;
      CSR_OP_CLEAR: return oldVal & ~info;
      default:      return oldVal;
    endcase
  endfunction

endpackage

// File: rtl/wb_if.sv
// Pipeline-to-WB bus plus the register-file write port and retire strobe.
interface wb_if;
  import wb_pkg::*;

  logic              wb_pipe_ready;
  logic              wb_pipe_flush;
  logic              wb_pipe_valid;
  logic [XLEN-1:0]   wb_pipe_pc;
  logic [XLEN-1:0]   wb_pipe_instruction;
  logic              wb_pipe_rd_write;
  logic [REG_AW-1:0] wb_pipe_rd_addr;
  logic [XLEN-1:0]   wb_pipe_rd_data;
  logic              wb_pipe_csr_write;
  logic              wb_pipe_csr_set;
  logic              wb_pipe_csr_clear;
  logic              wb_pipe_csr_read;
  logic [XLEN-1:0]   wb_pipe_csr_info;
  logic [11:0]       wb_pipe_csr_addr;
  logic              wb_rd_write;
  logic [REG_AW-1:0] wb_rd_addr;
  logic [XLEN-1:0]   wb_rd_wdata;
  logic              wb_retire;

  modport slave (
    output wb_pipe_ready, wb_pipe_flush, wb_rd_write, wb_rd_addr, wb_rd_wdata, wb_retire,
    input  wb_pipe_valid, wb_pipe_pc, wb_pipe_instruction, wb_pipe_rd_write,
           wb_pipe_rd_addr, wb_pipe_rd_data, wb_pipe_csr_write, wb_pipe_csr_set,
           wb_pipe_csr_clear, wb_pipe_csr_read, wb_pipe_csr_info, wb_pipe_csr_addr
  );

  modport master (
    input  wb_pipe_ready, wb_pipe_flush, wb_rd_write, wb_rd_addr, wb_rd_wdata, wb_retire,
    output wb_pipe_valid, wb_pipe_pc, wb_pipe_instruction, wb_pipe_rd_write,
           wb_pipe_rd_addr, wb_pipe_rd_data, wb_pipe_csr_write, wb_pipe_csr_set,
           wb_pipe_csr_clear, wb_pipe_csr_read, wb_pipe_csr_info, wb_pipe_csr_addr
  );

endinterface

// File: rtl/wb_csr_file.sv
// Machine CSRs and the mcycle/minstret counters; rdata_o is the pre-update value
// of the addressed CSR, and the update lands on the commit edge.
module wb_csr_file
  import wb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_b,
  input  logic            commit_i,
  input  csr_op_e         op_i,
  input  logic [11:0]     addr_i,
  input  logic [XLEN-1:0] info_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d, mcause_q, mcause_d;
  logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [XLEN-1:0] newVal;
  logic            wrEn;

  always_comb begin
    case (addr_i)
      CSR_MTVEC:                   rdata_o = mtvec_q;
      CSR_MEPC:                    rdata_o = mepc_q;
      CSR_MSCRATCH:                rdata_o = mscratch_q;
      CSR_MCAUSE:                  rdata_o = mcause_q;
      CSR_MCYCLE,   CSR_CYCLE:     rdata_o = mcycle_q[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    rdata_o = mcycle_q[63:32];
      CSR_MINSTRET, CSR_INSTRET:   rdata_o = minstret_q[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata_o = minstret_q[63:32];
      default:                     rdata_o = '0;
    endcase
  end

  // Set/clear with a zero mask is not a write, so it must not suppress a counter tick.
  always_comb begin
    newVal = csrApply(op_i, rdata_o, info_i);
    wrEn   = commit_i & ((op_i == CSR_OP_WRITE) | ((op_i != CSR_OP_NONE) & (info_i != '0)));
  end

  always_comb begin
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mscratch_d = mscratch_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = commit_i ? minstret_q + 64'd1 : minstret_q;
    if (wrEn) begin
      case (addr_i)
        CSR_MTVEC:     mtvec_d    = {newVal[XLEN-1:2], 2'b00};
        CSR_MEPC:      mepc_d     = {newVal[XLEN-1:2], 2'b00};
        CSR_MSCRATCH:  mscratch_d = newVal;
        CSR_MCAUSE:    mcause_d   = newVal;
        CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], newVal};
        CSR_MCYCLEH:   mcycle_d   = {newVal, mcycle_q[31:0]};
        CSR_MINSTRET:  minstret_d = {minstret_q[63:32], newVal};
        CSR_MINSTRETH: minstret_d = {newVal, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mscratch_q <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mscratch_q <= mscratch_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule

// File: rtl/wb.sv
// Write-back stage: commits the retiring instruction to the register file and,
// when Zicsr is present, performs its CSR read/modify/write.
module wb
  import wb_pkg::*;
#(
  parameter bit ISA_Zicsr = 1'b1
) (
  input logic clk,
  input logic rst_b,
  wb_if.slave pipe
);

  logic            commit;
  logic [XLEN-1:0] csrRdata;

  assign commit             = pipe.wb_pipe_valid;
  assign pipe.wb_pipe_ready = 1'b1;
  assign pipe.wb_pipe_flush = 1'b0;
  assign pipe.wb_retire     = commit;
  assign pipe.wb_rd_addr    = pipe.wb_pipe_rd_addr;
  assign pipe.wb_rd_write   = commit & pipe.wb_pipe_rd_write & (pipe.wb_pipe_rd_addr != '0);

  generate
    if (ISA_Zicsr) begin : gCsr
      csr_op_e csrOp;

      // Simultaneous op bits resolve write > set > clear.
      always_comb begin
        csrOp = CSR_OP_NONE;
        if (pipe.wb_pipe_csr_write)      csrOp = CSR_OP_WRITE;
        else if (pipe.wb_pipe_csr_set)   csrOp = CSR_OP_SET;
        else if (pipe.wb_pipe_csr_clear) csrOp = CSR_OP_CLEAR;
      end

      wb_csr_file uCsrFile (
        .clk      (clk),
        .rst_b    (rst_b),
        .commit_i (commit),
        .op_i     (csrOp),
        .addr_i   (pipe.wb_pipe_csr_addr),
        .info_i   (pipe.wb_pipe_csr_info),
        .rdata_o  (csrRdata)
      );

      assign pipe.wb_rd_wdata = pipe.wb_pipe_csr_read ? csrRdata : pipe.wb_pipe_rd_data;
    end else begin : gNoCsr
      assign csrRdata         = '0;
      assign pipe.wb_rd_wdata = pipe.wb_pipe_rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_wb.sv
// Bench for the write-back stage: fixed vectors, counter corner cases and random
// traffic compared against a CSR/counter model.
module tb_wb;
  import wb_pkg::*;

  typedef struct {
    logic        valid;
    logic        rdWrite;
    logic [4:0]  rdAddr;
    logic [31:0] rdData;
    logic [1:0]  op;
    logic        csrRead;
    logic [11:0] addr;
    logic [31:0] info;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        expWrite;
    logic [31:0] expWdata;
    logic        expRetire;
    bit          chkData;
  } vec_t;

  localparam logic [1:0] OP_NONE = 2'd0, OP_W = 2'd1, OP_S = 2'd2, OP_C = 2'd3;

  logic clk = 1'b0;
  logic rst_b;
  int   total = 0;
  int   bad   = 0;

  bit [31:0] mMtvec, mMepc, mMscratch, mMcause;
  bit [63:0] mCycle, mInstret;

  logic        seenWrite, seenRetire;
  logic [31:0] seenWdata;
  vec_t        vecs[20];
  logic [11:0] addrList[16] = '{12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02,
                                12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82,
                                12'h7C0, 12'h300, 12'hB00, 12'hB82};

  always #5 clk = ~clk;

  wb_if bus();

  wb #(.ISA_Zicsr(1'b1)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .pipe  (bus)
  );

  function automatic stim_t mk(logic valid, logic rdWrite, logic [4:0] rdAddr, logic [31:0] rdData,
                               logic [1:0] op, logic csrRead, logic [11:0] addr, logic [31:0] info);
    stim_t s;
    s.valid = valid; s.rdWrite = rdWrite; s.rdAddr = rdAddr; s.rdData = rdData;
    s.op = op; s.csrRead = csrRead; s.addr = addr; s.info = info;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 1'b0, 5'd0, 32'd0, OP_NONE, 1'b0, 12'h000, 32'd0);
  endfunction

  function automatic stim_t readCsr(logic [11:0] addr);
    return mk(1'b1, 1'b1, 5'd1, 32'd0, OP_S, 1'b1, addr, 32'd0);
  endfunction

  function automatic stim_t writeCsr(logic [11:0] addr, logic [31:0] val);
    return mk(1'b1, 1'b0, 5'd0, 32'd0, OP_W, 1'b0, addr, val);
  endfunction

  function automatic logic [31:0] modelRead(logic [11:0] a);
    case (a)
      12'h305: return mMtvec;
      12'h341: return mMepc;
      12'h340: return mMscratch;
      12'h342: return mMcause;
      12'hB00, 12'hC00: return mCycle[31:0];
      12'hB80, 12'hC80: return mCycle[63:32];
      12'hB02, 12'hC02: return mInstret[31:0];
      12'hB82, 12'hC82: return mInstret[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    mMtvec = 0; mMepc = 0; mMscratch = 0; mMcause = 0; mCycle = 0; mInstret = 0;
  endtask

  // One clock edge of architectural effect for the instruction in WB.
  task automatic modelStep(stim_t s);
    bit [31:0] oldV, newV;
    bit        touched, cycWritten, instWritten;
    cycWritten  = 1'b0;
    instWritten = 1'b0;
    touched = s.valid && (s.op == OP_W || (s.op != OP_NONE && s.info != 0));
    oldV = modelRead(s.addr);
    case (s.op)
      OP_W:    newV = s.info;
      OP_S:    newV = oldV | s.info;
      OP_C:    newV = oldV & ~s.info;
      default: newV = oldV;
    endcase
    if (touched) begin
      case (s.addr)
        12'h305: mMtvec    = newV & 32'hFFFF_FFFC;
        12'h341: mMepc     = newV & 32'hFFFF_FFFC;
        12'h340: mMscratch = newV;
        12'h342: mMcause   = newV;
        12'hB00: begin mCycle[31:0]    = newV; cycWritten  = 1'b1; end
        12'hB80: begin mCycle[63:32]   = newV; cycWritten  = 1'b1; end
        12'hB02: begin mInstret[31:0]  = newV; instWritten = 1'b1; end
        12'hB82: begin mInstret[63:32] = newV; instWritten = 1'b1; end
        default: ;
      endcase
    end
    if (!cycWritten) mCycle = mCycle + 64'd1;
    if (s.valid && !instWritten) mInstret = mInstret + 64'd1;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(stim_t s);
    bus.wb_pipe_valid       = s.valid;
    bus.wb_pipe_pc          = 32'h0000_1000;
    bus.wb_pipe_instruction = 32'h0000_0013;
    bus.wb_pipe_rd_write    = s.rdWrite;
    bus.wb_pipe_rd_addr     = s.rdAddr;
    bus.wb_pipe_rd_data     = s.rdData;
    bus.wb_pipe_csr_write   = (s.op == OP_W);
    bus.wb_pipe_csr_set     = (s.op == OP_S);
    bus.wb_pipe_csr_clear   = (s.op == OP_C);
    bus.wb_pipe_csr_read    = s.csrRead;
    bus.wb_pipe_csr_info    = s.info;
    bus.wb_pipe_csr_addr    = s.addr;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic runCycle(stim_t s);
    logic [31:0] expWdata;
    applyStimulus(s);
    #1;
    expWdata   = s.csrRead ? modelRead(s.addr) : s.rdData;
    seenWrite  = bus.wb_rd_write;
    seenRetire = bus.wb_retire;
    seenWdata  = bus.wb_rd_wdata;
    checkOutput("model rd_write", {31'd0, seenWrite}, {31'd0, s.valid & s.rdWrite & (s.rdAddr != 0)});
    checkOutput("model retire", {31'd0, seenRetire}, {31'd0, s.valid});
    if (s.valid) checkOutput($sformatf("model wdata @%h", s.addr), seenWdata, expWdata);
    modelStep(s);
    @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus(idle());
    rst_b = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    rst_b = 1'b0;
    applyStimulus(idle());
    modelReset();
    @(negedge clk);
    #1;
    checkOutput("reset ready", {31'd0, bus.wb_pipe_ready}, 32'd1);
    checkOutput("reset flush", {31'd0, bus.wb_pipe_flush}, 32'd0);
    checkOutput("reset retire", {31'd0, bus.wb_retire}, 32'd0);
    checkOutput("reset rd_write", {31'd0, bus.wb_rd_write}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Entry i runs with i cycles elapsed since reset release.
    vecs[0]  = '{mk(1, 1, 0, 32'hDEAD, OP_NONE, 0, 12'h000, 0), 1'b0, 32'hDEAD, 1'b1, 1'b1};
    vecs[1]  = '{mk(1, 1, 3, 32'h1234, OP_NONE, 0, 12'h000, 0), 1'b1, 32'h1234, 1'b1, 1'b1};
    vecs[2]  = '{mk(0, 1, 3, 32'h5555, OP_NONE, 0, 12'h000, 0), 1'b0, 32'h0,    1'b0, 1'b0};
    vecs[3]  = '{mk(1, 1, 1, 0, OP_W, 1, 12'h340, 32'hF0F0),         1'b1, 32'h0,        1'b1, 1'b1};
    vecs[4]  = '{mk(1, 1, 5, 0, OP_S, 1, 12'h340, 32'h0F0F),         1'b1, 32'hF0F0,     1'b1, 1'b1};
    vecs[5]  = '{mk(1, 1, 6, 0, OP_S, 1, 12'h340, 32'h0),            1'b1, 32'hFFFF,     1'b1, 1'b1};
    vecs[6]  = '{mk(1, 0, 7, 32'h77, OP_W, 0, 12'h341, 32'h80000003), 1'b0, 32'h77,      1'b1, 1'b1};
    vecs[7]  = '{mk(1, 1, 7, 0, OP_S, 1, 12'h341, 32'h0),            1'b1, 32'h80000000, 1'b1, 1'b1};
    vecs[8]  = '{mk(1, 0, 0, 0, OP_W, 0, 12'hC00, 32'h1234),         1'b0, 32'h0,        1'b1, 1'b1};
    vecs[9]  = '{mk(1, 0, 0, 0, OP_W, 0, 12'h7C0, 32'h1234),         1'b0, 32'h0,        1'b1, 1'b1};
    vecs[10] = '{mk(1, 1, 8, 0, OP_S, 1, 12'h7C0, 32'h0),            1'b1, 32'h0,        1'b1, 1'b1};
    vecs[11] = '{mk(1, 1, 9, 0, OP_C, 1, 12'h340, 32'h00FF),         1'b1, 32'hFFFF,     1'b1, 1'b1};
    vecs[12] = '{mk(1, 1, 9, 0, OP_S, 1, 12'h340, 32'h0),            1'b1, 32'hFF00,     1'b1, 1'b1};
    vecs[13] = '{mk(1, 0, 0, 0, OP_W, 0, 12'h305, 32'hFFFFFFFF),     1'b0, 32'h0,        1'b1, 1'b1};
    vecs[14] = '{mk(1, 1, 10, 0, OP_S, 1, 12'h305, 32'h0),           1'b1, 32'hFFFFFFFC, 1'b1, 1'b1};
    vecs[15] = '{mk(1, 1, 11, 0, OP_S, 1, 12'hC00, 32'h0),           1'b1, 32'd15,       1'b1, 1'b1};
    vecs[16] = '{mk(1, 1, 12, 0, OP_S, 1, 12'hC02, 32'h0),           1'b1, 32'd15,       1'b1, 1'b1};
    vecs[17] = '{mk(1, 1, 13, 0, OP_C, 1, 12'h342, 32'hFFFFFFFF),    1'b1, 32'h0,        1'b1, 1'b1};
    vecs[18] = '{mk(1, 0, 0, 0, OP_W, 0, 12'h342, 32'hABCD),         1'b0, 32'h0,        1'b1, 1'b1};
    vecs[19] = '{mk(1, 1, 14, 0, OP_S, 1, 12'h342, 32'h0),           1'b1, 32'hABCD,     1'b1, 1'b1};

    for (int i = 0; i < 20; i++) begin
      runCycle(vecs[i].s);
      checkOutput($sformatf("vec%0d rd_write", i), {31'd0, seenWrite}, {31'd0, vecs[i].expWrite});
      checkOutput($sformatf("vec%0d retire", i), {31'd0, seenRetire}, {31'd0, vecs[i].expRetire});
      if (vecs[i].chkData)
        checkOutput($sformatf("vec%0d wdata", i), seenWdata, vecs[i].expWdata);
    end

    doReset();
    repeat (10) runCycle(idle());
    runCycle(readCsr(12'hB00));
    checkOutput("mcycle after 10", seenWdata, 32'd10);
    doReset();
    repeat (10) runCycle(idle());
    runCycle(readCsr(12'hB02));
    checkOutput("minstret idle", seenWdata, 32'd0);

    doReset();
    runCycle(writeCsr(12'hB02, 32'hFFFF_FFFF));
    runCycle(readCsr(12'hB82));
    checkOutput("minstreth pre-carry", seenWdata, 32'd0);
    runCycle(readCsr(12'hB02));
    checkOutput("minstret post-carry lo", seenWdata, 32'd0);
    runCycle(readCsr(12'hB82));
    checkOutput("minstret post-carry hi", seenWdata, 32'd1);
    runCycle(writeCsr(12'hB02, 32'd5));
    runCycle(readCsr(12'hB02));
    checkOutput("minstret write wins", seenWdata, 32'd5);

    runCycle(writeCsr(12'hB80, 32'hFFFF_FFFF));
    runCycle(writeCsr(12'hB00, 32'hFFFF_FFFF));
    runCycle(idle());
    runCycle(readCsr(12'hB00));
    checkOutput("mcycle wrap lo", seenWdata, 32'd0);
    runCycle(readCsr(12'hB80));
    checkOutput("mcycle wrap hi", seenWdata, 32'd0);

    // Reset lands while a CSR write is waiting for its commit edge.
    applyStimulus(writeCsr(12'h340, 32'h5A5A));
    #2;
    rst_b = 1'b0;
    modelReset();
    @(negedge clk);
    applyStimulus(idle());
    @(negedge clk);
    rst_b = 1'b1;
    runCycle(readCsr(12'h340));
    checkOutput("mscratch after reset", seenWdata, 32'd0);
    runCycle(readCsr(12'hB00));
    checkOutput("mcycle restart", seenWdata, 32'd1);

    doReset();
    for (int n = 0; n < 400; n++) begin
      stim_t s;
      s.valid   = ($urandom_range(0, 3) != 0);
      s.rdWrite = $urandom_range(0, 1) == 1;
      s.rdAddr  = 5'($urandom_range(0, 31));
      s.rdData  = $urandom;
      s.op      = 2'($urandom_range(0, 3));
      s.csrRead = $urandom_range(0, 1) == 1;
      s.addr    = addrList[$urandom_range(0, 15)];
      case ($urandom_range(0, 3))
        0:       s.info = 32'd0;
        1:       s.info = 32'hFFFF_FFFF;
        default: s.info = $urandom;
      endcase
      runCycle(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
